// File: rtl/prefetch_queue.sv
// prefetch_queue
// Instruction-byte prefetcher that sits upstream of the 6502 fetcher. It reads
// memory sequentially, keeps the bytes in a small FIFO, and hands them to the
// consumer in program order through a valid/ready handshake. A flush moves the
// fetch stream to a new address after a branch or jump. A hold stops new reads
// while the fetcher is using the bus.
//
// Ports
//   phi1        clock; all state changes on its rising edge
//   reset       asynchronous, active-high reset
//   mem_addr    registered read address
//   mem_rd      registered read strobe
//   mem_data    read data, valid in the same cycle as mem_rd
//   hold        suppresses new reads while the fetcher owns the bus
//   flush       drops the queued bytes and restarts fetching at flush_addr
//   flush_addr  new fetch address
//   byte_out    byte at the head of the queue
//   byte_valid  byte_out is valid (level != 0)
//   byte_ready  consumer takes byte_out at this edge
//   head_pc     address of byte_out
//   level       number of entries held
//   full        level == DEPTH
module prefetch_queue #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(16'h8000)
) (
    input  logic                         phi1,
    input  logic                         reset,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_rd,
    input  logic [REG_WIDTH-1:0]         mem_data,
    input  logic                         hold,
    input  logic                         flush,
    input  logic [ADDR_WIDTH-1:0]        flush_addr,
    output logic [REG_WIDTH-1:0]         byte_out,
    output logic                         byte_valid,
    input  logic                         byte_ready,
    output logic [ADDR_WIDTH-1:0]        head_pc,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam logic [LEVEL_W-1:0] DEPTH_LVL = LEVEL_W'(DEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state;
    logic [REG_WIDTH-1:0] fifo [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;
    logic [LEVEL_W-1:0]   next_level;

    // A read strobed in this cycle is always pushed at the next edge. Only one
    // read is ever outstanding, so deciding the next strobe from next_level
    // is enough to keep the FIFO from overflowing.
    always_comb begin
        push       = mem_rd;
        pop        = byte_valid && byte_ready;
        next_level = level + LEVEL_W'(push) - LEVEL_W'(pop);
    end

    // byte_out is a mux over register contents with no path from any input.
    // This is what allows a byte to be taken in the same cycle it is presented.
    assign byte_out = fifo[rd_ptr];

    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            mem_addr   <= RESET_PC;
            mem_rd     <= 1'b0;
            head_pc    <= RESET_PC;
            level      <= '0;
            byte_valid <= 1'b0;
            full       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            case (state)
                BOOT: begin
                    // One idle cycle after reset. No read is issued here.
                    state <= RUN;
                    if (flush) begin
                        mem_addr <= flush_addr;
                        head_pc  <= flush_addr;
                    end
                end
                default: begin
                    state <= hold ? HOLD : RUN;
                    if (flush) begin
                        // Redirect. Any in-flight byte and any pop at this
                        // edge are dropped. The first new read issues one edge later.
                        level      <= '0;
                        byte_valid <= 1'b0;
                        full       <= 1'b0;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        mem_addr   <= flush_addr;
                        head_pc    <= flush_addr;
                        mem_rd     <= 1'b0;
                    end else begin
                        if (push) begin
                            fifo[wr_ptr] <= mem_data;
                            wr_ptr       <= wr_ptr + PTR_W'(1);
                            mem_addr     <= mem_addr + ADDR_WIDTH'(1);
                        end
                        if (pop) begin
                            rd_ptr  <= rd_ptr + PTR_W'(1);
                            head_pc <= head_pc + ADDR_WIDTH'(1);
                        end
                        level      <= next_level;
                        byte_valid <= (next_level != '0);
                        full       <= (next_level == DEPTH_LVL);
                        mem_rd     <= !hold && (next_level < DEPTH_LVL);
                    end
                end
            endcase
        end
    end

endmodule
